// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared state encoding and default parameters for the round timer
package game_timer_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        EXPIRED = 3'd3
    } state_e;
    localparam int TICK_DIV_DEF  = 5000;
    localparam int INIT_TIME_DEF = 1800000;
    localparam int PENALTY_DEF   = 10;
    localparam int TIME_W_DEF    = 21;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock into one terminal-count cycle per TICK_DIV enabled cycles
module tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic terminal
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign terminal = (cnt_q == CW'(TICK_DIV - 1));
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : terminal ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: round FSM owning the remaining-time register, tick decrement and miss penalties
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int INIT_TIME = INIT_TIME_DEF,
    parameter int PENALTY   = PENALTY_DEF,
    parameter int TIME_W    = TIME_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic              miss,
    output logic [TIME_W-1:0] time_left,
    output logic              tick,
    output logic              running,
    output logic              paused,
    output logic              game_fail,
    output logic [7:0]        miss_cnt,
    output logic [2:0]        state
);
    state_e            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;
    logic              tick_q, tick_d, running_q, paused_q, fail_q;
    logic              terminal, apply, reload, expire;
    logic [TIME_W:0]   ded;
    // Only an undisturbed RUN cycle advances the prescaler or deducts time
    assign apply  = (state_q == RUN) && !abort && !pause;
    assign reload = start && !abort && (state_q == IDLE || state_q == EXPIRED);
    assign ded    = {{TIME_W{1'b0}}, terminal} + (miss ? (TIME_W+1)'(PENALTY) : '0);
    assign expire = apply && (ded != '0) && (ded >= {1'b0, time_q});
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clock    (clock),
        .reset    (reset),
        .clr      (abort || reload || expire || state_q == IDLE || state_q == EXPIRED),
        .en       (apply),
        .terminal (terminal)
    );
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        miss_cnt_d = miss_cnt_q;
        tick_d     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            time_d  = TIME_W'(INIT_TIME);
        end else if (reload) begin
            state_d    = RUN;
            time_d     = TIME_W'(INIT_TIME);
            miss_cnt_d = '0;
        end else if (pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (pause && state_q == PAUSE) begin
            state_d = RUN;
        end else if (apply) begin
            time_d     = expire ? '0 : time_q - ded[TIME_W-1:0];
            state_d    = expire ? EXPIRED : RUN;
            tick_d     = terminal;
            miss_cnt_d = (miss && miss_cnt_q != 8'hff) ? miss_cnt_q + 8'd1 : miss_cnt_q;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            time_q     <= TIME_W'(INIT_TIME);
            miss_cnt_q <= '0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            miss_cnt_q <= miss_cnt_d;
            tick_q     <= tick_d;
            running_q  <= (state_d == RUN);
            paused_q   <= (state_d == PAUSE);
            fail_q     <= (state_d == EXPIRED);
        end
    end
    assign time_left = time_q;
    assign tick      = tick_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign game_fail = fail_q;
    assign miss_cnt  = miss_cnt_q;
    assign state     = state_q;
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed scenarios for the round timer with TICK_DIV=4, INIT_TIME=30, PENALTY=10
module tb_game_timer_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, pause = 1'b0, abort = 1'b0, miss = 1'b0;
    logic [20:0] time_left;
    logic        tick, running, paused, game_fail;
    logic [7:0]  miss_cnt;
    logic [2:0]  state;
    int vectors = 0;
    int miscompares = 0;

    game_timer_ctrl #(.TICK_DIV(4), .INIT_TIME(30), .PENALTY(10), .TIME_W(21)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .abort(abort), .miss(miss),
        .time_left(time_left), .tick(tick), .running(running), .paused(paused),
        .game_fail(game_fail), .miss_cnt(miss_cnt), .state(state)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic a, input logic m);
        start = s; pause = p; abort = a; miss = m;
        step();
        start = 0; pause = 0; abort = 0; miss = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        #12;
        vectors++; if (time_left !== 21'd30) begin $display("FAIL reset_time got %0d expected 30", time_left); miscompares++; end
        vectors++; if ({state, running, paused, game_fail, tick} !== 7'b0) begin $display("FAIL reset_flags got %b expected 0", {state, running, paused, game_fail, tick}); miscompares++; end
        vectors++; if (miss_cnt !== 8'd0) begin $display("FAIL reset_misscnt got %0d expected 0", miss_cnt); miscompares++; end
        @(negedge clock);
        reset = 1;
        step(3);
        vectors++; if (state !== 3'd0 || time_left !== 21'd30) begin $display("FAIL idle_hold got state %0d time %0d expected 0/30", state, time_left); miscompares++; end
    endtask

    task automatic test_start_tick();
        pulse(1, 0, 0, 0);
        vectors++; if (running !== 1'b1 || state !== 3'd1) begin $display("FAIL start_run got run %b state %0d expected 1/1", running, state); miscompares++; end
        step(3);
        vectors++; if (time_left !== 21'd30 || tick !== 1'b0) begin $display("FAIL pre_tick got time %0d tick %b expected 30/0", time_left, tick); miscompares++; end
        step();
        vectors++; if (time_left !== 21'd29 || tick !== 1'b1) begin $display("FAIL first_tick got time %0d tick %b expected 29/1", time_left, tick); miscompares++; end
        step();
        vectors++; if (tick !== 1'b0) begin $display("FAIL tick_width got %b expected 0", tick); miscompares++; end
    endtask

    task automatic test_miss();
        pulse(0, 0, 0, 1);
        vectors++; if (time_left !== 21'd19 || miss_cnt !== 8'd1 || tick !== 1'b0) begin $display("FAIL miss_plain got time %0d cnt %0d tick %b expected 19/1/0", time_left, miss_cnt, tick); miscompares++; end
        step();
        pulse(0, 0, 0, 1);
        vectors++; if (time_left !== 21'd8 || miss_cnt !== 8'd2 || tick !== 1'b1) begin $display("FAIL miss_terminal got time %0d cnt %0d tick %b expected 8/2/1", time_left, miss_cnt, tick); miscompares++; end
    endtask

    task automatic test_pause();
        logic bad = 0;
        step();
        pulse(0, 1, 0, 0);
        vectors++; if (paused !== 1'b1 || running !== 1'b0 || state !== 3'd2) begin $display("FAIL pause_enter got paused %b run %b state %0d expected 1/0/2", paused, running, state); miscompares++; end
        for (int i = 0; i < 40; i++) begin
            miss = (i == 7 || i == 25);
            step();
            if (time_left !== 21'd8 || miss_cnt !== 8'd2 || tick !== 1'b0) bad = 1;
        end
        miss = 0;
        vectors++; if (bad !== 1'b0) begin $display("FAIL pause_freeze got time %0d cnt %0d expected 8/2", time_left, miss_cnt); miscompares++; end
        pulse(0, 1, 0, 0);
        vectors++; if (running !== 1'b1 || paused !== 1'b0) begin $display("FAIL pause_resume got run %b paused %b expected 1/0", running, paused); miscompares++; end
        step(2);
        vectors++; if (time_left !== 21'd8 || tick !== 1'b0) begin $display("FAIL resume_early got time %0d tick %b expected 8/0", time_left, tick); miscompares++; end
        step();
        vectors++; if (time_left !== 21'd7 || tick !== 1'b1) begin $display("FAIL resume_tick got time %0d tick %b expected 7/1", time_left, tick); miscompares++; end
    endtask

    task automatic test_expire();
        logic seen = 0;
        pulse(0, 0, 0, 1);
        vectors++; if (time_left !== 21'd0 || game_fail !== 1'b1 || state !== 3'd3 || running !== 1'b0) begin $display("FAIL expire got time %0d fail %b state %0d expected 0/1/3", time_left, game_fail, state); miscompares++; end
        vectors++; if (tick !== 1'b0 || miss_cnt !== 8'd3) begin $display("FAIL expire_tick got tick %b cnt %0d expected 0/3", tick, miss_cnt); miscompares++; end
        for (int i = 0; i < 12; i++) begin
            miss = (i == 3);
            pause = (i == 6);
            step();
            if (tick !== 1'b0 || time_left !== 21'd0 || state !== 3'd3) seen = 1;
        end
        miss = 0; pause = 0;
        vectors++; if (seen !== 1'b0 || miss_cnt !== 8'd3) begin $display("FAIL expired_hold got time %0d cnt %0d expected 0/3", time_left, miss_cnt); miscompares++; end
        pulse(1, 0, 0, 0);
        vectors++; if (time_left !== 21'd30 || running !== 1'b1 || game_fail !== 1'b0 || miss_cnt !== 8'd0) begin $display("FAIL restart got time %0d run %b fail %b cnt %0d expected 30/1/0/0", time_left, running, game_fail, miss_cnt); miscompares++; end
    endtask

    task automatic test_abort();
        pulse(0, 0, 0, 1);
        vectors++; if (time_left !== 21'd20 || miss_cnt !== 8'd1) begin $display("FAIL pre_abort got time %0d cnt %0d expected 20/1", time_left, miss_cnt); miscompares++; end
        pulse(1, 0, 1, 0);
        vectors++; if (state !== 3'd0 || time_left !== 21'd30 || running !== 1'b0 || miss_cnt !== 8'd1) begin $display("FAIL abort_start got state %0d time %0d cnt %0d expected 0/30/1", state, time_left, miss_cnt); miscompares++; end
        pulse(0, 1, 0, 1);
        step(5);
        vectors++; if (state !== 3'd0 || time_left !== 21'd30 || paused !== 1'b0 || tick !== 1'b0) begin $display("FAIL idle_ignore got state %0d time %0d expected 0/30", state, time_left); miscompares++; end
    endtask

    task automatic test_async_reset();
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        vectors++; if (time_left !== 21'd20 || running !== 1'b1) begin $display("FAIL pre_reset got time %0d run %b expected 20/1", time_left, running); miscompares++; end
        #2;
        reset = 0;
        #1;
        vectors++; if (state !== 3'd0 || time_left !== 21'd30 || running !== 1'b0 || miss_cnt !== 8'd0) begin $display("FAIL async_reset got state %0d time %0d cnt %0d expected 0/30/0", state, time_left, miss_cnt); miscompares++; end
        @(negedge clock);
        reset = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_miss();
        test_pause();
        test_expire();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Round controller for the countdown-timer display path: it owns the remaining-time register, prescales the system clock into decrement ticks, applies miss penalties, and sequences the round through idle, running, paused and expired states. It sits between the game-logic inputs (start/pause/abort/miss) and the seven-segment timer display, which consumes `time_left` and `game_fail`.

## Interface
Parameters:
- `TICK_DIV`, 5000: clock cycles per one-unit decrement (0.1 ms at 50 MHz).
- `INIT_TIME`, 1800000: value loaded into `time_left` at reset, on `start` and on `abort`.
- `PENALTY`, 10: units deducted per accepted `miss`.
- `TIME_W`, 21: width of `time_left`; `INIT_TIME` must fit.

Ports:
- `clock`, in, 1: the single clock; all logic rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; begins a round from IDLE or EXPIRED.
- `pause`, in, 1: one-cycle pulse; toggles RUN and PAUSE.
- `abort`, in, 1: one-cycle pulse; returns to IDLE from any state.
- `miss`, in, 1: one-cycle synchronous pulse (pre-debounced); requests a penalty.
- `time_left`, out, TIME_W: remaining time, registered.
- `tick`, out, 1: high for one cycle when `time_left` shows a new tick-decremented value.
- `running`, out, 1: state == RUN.
- `paused`, out, 1: state == PAUSE.
- `game_fail`, out, 1: state == EXPIRED.
- `miss_cnt`, out, 8: accepted misses this round, saturates at 255.
- `state`, out, 3: current state encoding.

## Operation
- States: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- Reset values: state IDLE, `time_left`=INIT_TIME, prescaler 0, `tick`=0, `miss_cnt`=0, all flags 0.
- Input priority in one cycle: `abort` > `start` > `pause` > `miss`/tick.
- IDLE: prescaler held at 0; `start` → RUN with `time_left`=INIT_TIME and `miss_cnt`=0.
- RUN: prescaler counts 0..TICK_DIV-1. The terminal count is the cycle where the prescaler equals TICK_DIV-1.
  - At terminal count the decrement is 1.
  - On an accepted `miss` the deduction is PENALTY and `miss_cnt` increments.
  - When both occur in the same cycle, the deduction is 1+PENALTY.
  - Arithmetic is saturating: if the deduction is ≥ `time_left`, the new value is 0.
- Reaching 0 in RUN → EXPIRED on the same edge. The prescaler resets to 0.
- `pause` in RUN → PAUSE. PAUSE freezes the prescaler value and `time_left`, and ignores `miss`. `pause` in PAUSE → RUN, and the prescaler resumes from its frozen value.
- EXPIRED: `time_left` holds 0, no ticks, `miss` is ignored; `start` → RUN with reload.
- `start` in RUN/PAUSE is ignored. `pause` in IDLE/EXPIRED is ignored.
- `abort` from any state → IDLE: `time_left`=INIT_TIME, prescaler 0, `miss_cnt` retained until the next `start`.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `start` sampled at edge k: `running`=1 and prescaler=0 from cycle k+1. The first decrement is visible at cycle k+1+TICK_DIV, and `tick` is high in that cycle only.
- `miss` sampled at edge k: the reduced `time_left` and incremented `miss_cnt` are visible from cycle k+1.
- A miss coinciding with the terminal count gives one combined update and `tick`=1.
- Expiry: `time_left`=0 and `game_fail`=1 become visible in the same cycle. `tick` is asserted if the expiring update was a tick.
- Asynchronous reset mid-round forces reset values immediately, independent of the clock.

## Structure
- Package `game_timer_pkg`:
  - state enum (IDLE/RUN/PAUSE/EXPIRED, 3-bit);
  - default constants TICK_DIV_DEF, INIT_TIME_DEF, PENALTY_DEF, TIME_W_DEF.
- Sub-module `tick_prescaler`:
  - inputs: `clock`, `reset`, `clr`, `en`;
  - output: `terminal`;
  - `en`=0 freezes the count and `clr` zeroes it.
- The FSM, saturating subtractor and `miss_cnt` live in `game_timer_ctrl`.

## Test plan
Bench parameters: TICK_DIV=4, INIT_TIME=30, PENALTY=10.
- Reset low, then release → IDLE, `time_left`=30, all flags 0; `start` → `running`=1, and 4 cycles later `time_left`=29 with a single-cycle `tick`.
- `miss` in RUN at 29 → 19 next cycle, `miss_cnt`=1; `miss` on the terminal-count cycle at 19 → 8 and `tick`=1.
- `pause` mid-prescale, hold 40 cycles with two `miss` pulses → `time_left` and `miss_cnt` unchanged; `pause` again → next decrement after exactly the remaining prescaler cycles.
- `miss` at `time_left`=8 → 0, `game_fail`=1, no further `tick`; `start` → `time_left`=30, RUN, `game_fail`=0, `miss_cnt`=0.
- `abort` and `start` in the same cycle while in RUN → IDLE with 30. Reset asserted mid-RUN between clock edges → IDLE, 30 immediately.
